// File: rtl/uart_rx_packet_if.sv
// Byte-stream input, held-packet output and buffer read port of the packet deframer.
// The deframer takes the slave side; the command logic and byte source take the master side.
interface uart_rx_packet_if #(
    parameter int IDX_W = 4
);
    logic [7:0]       RX_DATA;
    logic             RX_RECV;
    logic             PKT_VALID;
    logic [7:0]       PKT_ADDR;
    logic [7:0]       PKT_LEN;
    logic             PKT_ACK;
    logic [IDX_W-1:0] RD_IDX;
    logic [7:0]       RD_DATA;
    logic             ERR_CSUM;
    logic             ERR_LEN;
    logic             ERR_TIMEOUT;
    logic             OVERRUN;

    modport slave (
        input  RX_DATA, RX_RECV, PKT_ACK, RD_IDX,
        output PKT_VALID, PKT_ADDR, PKT_LEN, RD_DATA,
        output ERR_CSUM, ERR_LEN, ERR_TIMEOUT, OVERRUN
    );

    modport master (
        output RX_DATA, RX_RECV, PKT_ACK, RD_IDX,
        input  PKT_VALID, PKT_ADDR, PKT_LEN, RD_DATA,
        input  ERR_CSUM, ERR_LEN, ERR_TIMEOUT, OVERRUN
    );
endinterface

// File: rtl/uart_rx_packet.sv
// Deframes SYNC/ADDR/LEN/payload/CSUM packets from a UART byte stream and holds a
// checksum-verified packet in a buffer until the consumer acknowledges it.
module uart_rx_packet #(
    parameter int         MAX_LEN = 16,
    parameter int         IDX_W   = 4,
    parameter logic [7:0] SYNC    = 8'h55,
    parameter int         TIMEOUT = 50000
) (
    input logic                 CLK,
    input logic                 RST,
    uart_rx_packet_if.slave     bus
);
    localparam int               TW         = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]    TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [7:0]       MAX_LEN_B  = 8'(MAX_LEN);
    localparam int               DEPTH      = 1 << IDX_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LEN,
        S_PAYLOAD,
        S_CSUM,
        S_HOLD
    } state_t;

    state_t          state_reg;
    logic [7:0]      sum_reg;
    logic [7:0]      frame_addr_reg;
    logic [7:0]      frame_len_reg;
    logic [7:0]      cnt_reg;
    logic [TW-1:0]   timer_reg;

    // Sized to the full index range so any RD_IDX is a legal address.
    logic [7:0]      mem [0:DEPTH-1];
    logic            wr_en;

    assign wr_en = bus.RX_RECV && (state_reg == S_PAYLOAD) && !RST;

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[cnt_reg[IDX_W-1:0]] <= bus.RX_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            bus.RD_DATA <= 8'h00;
        end else begin
            bus.RD_DATA <= mem[bus.RD_IDX];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg       <= S_IDLE;
            sum_reg         <= 8'h00;
            frame_addr_reg  <= 8'h00;
            frame_len_reg   <= 8'h00;
            cnt_reg         <= 8'h00;
            timer_reg       <= '0;
            bus.PKT_VALID   <= 1'b0;
            bus.PKT_ADDR    <= 8'h00;
            bus.PKT_LEN     <= 8'h00;
            bus.ERR_CSUM    <= 1'b0;
            bus.ERR_LEN     <= 1'b0;
            bus.ERR_TIMEOUT <= 1'b0;
            bus.OVERRUN     <= 1'b0;
        end else begin
            bus.ERR_CSUM    <= 1'b0;
            bus.ERR_LEN     <= 1'b0;
            bus.ERR_TIMEOUT <= 1'b0;
            bus.OVERRUN     <= 1'b0;

            case (state_reg)
                S_IDLE: begin
                    timer_reg <= '0;
                    if (bus.RX_RECV && bus.RX_DATA == SYNC) begin
                        state_reg <= S_ADDR;
                        sum_reg   <= 8'h00;
                    end
                end

                S_HOLD: begin
                    timer_reg <= '0;
                    // Ack takes priority; a coincident byte is treated as arriving in IDLE.
                    if (bus.PKT_ACK) begin
                        bus.PKT_VALID <= 1'b0;
                        state_reg     <= S_IDLE;
                        if (bus.RX_RECV && bus.RX_DATA == SYNC) begin
                            state_reg <= S_ADDR;
                            sum_reg   <= 8'h00;
                        end
                    end else if (bus.RX_RECV) begin
                        bus.OVERRUN <= 1'b1;
                    end
                end

                default: begin
                    if (bus.RX_RECV) begin
                        timer_reg <= '0;
                        case (state_reg)
                            S_ADDR: begin
                                frame_addr_reg <= bus.RX_DATA;
                                sum_reg        <= bus.RX_DATA;
                                state_reg      <= S_LEN;
                            end
                            S_LEN: begin
                                if (bus.RX_DATA > MAX_LEN_B) begin
                                    bus.ERR_LEN <= 1'b1;
                                    state_reg   <= S_IDLE;
                                end else begin
                                    sum_reg       <= sum_reg + bus.RX_DATA;
                                    frame_len_reg <= bus.RX_DATA;
                                    cnt_reg       <= 8'h00;
                                    state_reg     <= (bus.RX_DATA == 8'h00) ? S_CSUM : S_PAYLOAD;
                                end
                            end
                            S_PAYLOAD: begin
                                sum_reg <= sum_reg + bus.RX_DATA;
                                cnt_reg <= cnt_reg + 8'd1;
                                if (cnt_reg + 8'd1 == frame_len_reg) begin
                                    state_reg <= S_CSUM;
                                end
                            end
                            S_CSUM: begin
                                if (bus.RX_DATA == sum_reg) begin
                                    bus.PKT_VALID <= 1'b1;
                                    bus.PKT_ADDR  <= frame_addr_reg;
                                    bus.PKT_LEN   <= frame_len_reg;
                                    state_reg     <= S_HOLD;
                                end else begin
                                    bus.ERR_CSUM <= 1'b1;
                                    state_reg    <= S_IDLE;
                                end
                            end
                            default: state_reg <= S_IDLE;
                        endcase
                    end else if (timer_reg == TIMER_LAST) begin
                        bus.ERR_TIMEOUT <= 1'b1;
                        timer_reg       <= '0;
                        state_reg       <= S_IDLE;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_packet.sv
// Directed bench for uart_rx_packet: table of frames with hand-computed results,
// followed by hand-written timeout, hold/overrun and reset sequences.
module tb_uart_rx_packet;
    localparam int TIMEOUT = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_rx_packet_if #(.IDX_W(4)) bus ();

    uart_rx_packet #(
        .MAX_LEN(16),
        .IDX_W  (4),
        .SYNC   (8'h55),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic [191:0] bytes;
        logic [7:0]   n;
        logic         exp_valid;
        logic [7:0]   exp_addr;
        logic [7:0]   exp_len;
        logic [7:0]   exp_csum;
        logic [7:0]   exp_lenerr;
        logic         do_ack;
    } vec_t;

    vec_t vecs [0:7];

    int total  = 0;
    int passed = 0;

    int n_csum = 0, n_len = 0, n_to = 0, n_ovr = 0;
    int s_csum, s_len, s_to, s_ovr;

    always @(negedge clk) begin
        if (bus.ERR_CSUM)    n_csum++;
        if (bus.ERR_LEN)     n_len++;
        if (bus.ERR_TIMEOUT) n_to++;
        if (bus.OVERRUN)     n_ovr++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.RX_DATA = b;
        bus.RX_RECV = 1'b1;
        tick();
        bus.RX_RECV = 1'b0;
    endtask

    task automatic snap();
        s_csum = n_csum; s_len = n_len; s_to = n_to; s_ovr = n_ovr;
    endtask

    function automatic logic [7:0] vbyte(input vec_t v, input int i);
        return v.bytes[8*(int'(v.n) - 1 - i) +: 8];
    endfunction

    task automatic run_vec(input int k);
        vec_t v;
        v = vecs[k];
        snap();
        for (int i = 0; i < int'(v.n); i++) send_byte(vbyte(v, i));
        chk($sformatf("v%0d valid", k), 32'(bus.PKT_VALID), 32'(v.exp_valid));
        chk($sformatf("v%0d addr", k), 32'(bus.PKT_ADDR), 32'(v.exp_addr));
        chk($sformatf("v%0d len", k), 32'(bus.PKT_LEN), 32'(v.exp_len));
        tick();
        chk($sformatf("v%0d err_csum", k), 32'(n_csum - s_csum), 32'(v.exp_csum));
        chk($sformatf("v%0d err_len", k), 32'(n_len - s_len), 32'(v.exp_lenerr));
        chk($sformatf("v%0d err_to", k), 32'(n_to - s_to), 32'd0);
        chk($sformatf("v%0d overrun", k), 32'(n_ovr - s_ovr), 32'd0);
        if (v.exp_valid) begin
            for (int i = 0; i < int'(v.exp_len); i++) begin
                bus.RD_IDX = 4'(i);
                tick();
                chk($sformatf("v%0d rd[%0d]", k, i), 32'(bus.RD_DATA), 32'(vbyte(v, 3 + i)));
            end
            if (v.do_ack) begin
                bus.PKT_ACK = 1'b1;
                tick();
                bus.PKT_ACK = 1'b0;
                chk($sformatf("v%0d ack", k), 32'(bus.PKT_VALID), 32'd0);
            end
        end
    endtask

    initial begin
        int fired_at;
        bus.RX_DATA = 8'h00;
        bus.RX_RECV = 1'b0;
        bus.PKT_ACK = 1'b0;
        bus.RD_IDX  = '0;

        //                bytes (first byte most significant)                          n   vld addr   len   csum  lerr  ack
        vecs[0] = '{192'({8'h55,8'h12,8'h03,8'h0A,8'h0B,8'h0C,8'h36}),                8'd7,  1'b1, 8'h12, 8'h03, 8'd0, 8'd0, 1'b1};
        vecs[1] = '{192'({8'h55,8'h12,8'h03,8'h0A,8'h0B,8'h0C,8'h3D}),                8'd7,  1'b0, 8'h12, 8'h03, 8'd1, 8'd0, 1'b0};
        vecs[2] = '{192'({8'h55,8'h07,8'h00,8'h07}),                                  8'd4,  1'b1, 8'h07, 8'h00, 8'd0, 8'd0, 1'b1};
        vecs[3] = '{192'({8'h00,8'hFF,8'hAA,8'h55,8'h01,8'h11}),                      8'd6,  1'b0, 8'h07, 8'h00, 8'd0, 8'd1, 1'b0};
        vecs[4] = '{192'({8'h55,8'h01,8'h55,8'h01,8'h02,8'h03}),                      8'd6,  1'b0, 8'h07, 8'h00, 8'd0, 8'd1, 1'b0};
        vecs[5] = '{192'({8'h55,8'h20,8'h10,8'h01,8'h02,8'h03,8'h04,8'h05,8'h06,8'h07,8'h08,
                          8'h09,8'h0A,8'h0B,8'h0C,8'h0D,8'h0E,8'h0F,8'h10,8'hB8}),    8'd20, 1'b1, 8'h20, 8'h10, 8'd0, 8'd0, 1'b1};
        vecs[6] = '{192'({8'h55,8'hAB,8'h02,8'hFF,8'h03,8'hAF}),                      8'd6,  1'b1, 8'hAB, 8'h02, 8'd0, 8'd0, 1'b1};
        vecs[7] = '{192'({8'h55,8'h12,8'h03,8'h0A,8'h0B,8'h0C,8'h36}),                8'd7,  1'b1, 8'h12, 8'h03, 8'd0, 8'd0, 1'b0};

        repeat (3) tick();
        chk("rst valid", 32'(bus.PKT_VALID), 32'd0);
        chk("rst addr", 32'(bus.PKT_ADDR), 32'd0);
        chk("rst len", 32'(bus.PKT_LEN), 32'd0);
        chk("rst rd_data", 32'(bus.RD_DATA), 32'd0);
        chk("rst pulses", 32'({bus.ERR_CSUM, bus.ERR_LEN, bus.ERR_TIMEOUT, bus.OVERRUN}), 32'd0);
        rst = 1'b0;
        tick();

        for (int k = 0; k < 7; k++) run_vec(k);

        // Timeout after SYNC ADDR, then a fresh frame must still decode.
        snap();
        send_byte(8'h55);
        send_byte(8'h12);
        fired_at = -1;
        for (int c = 1; c <= TIMEOUT + 20; c++) begin
            tick();
            if (fired_at < 0 && bus.ERR_TIMEOUT) fired_at = c;
        end
        chk("timeout count", 32'(n_to - s_to), 32'd1);
        chk("timeout not early", 32'(fired_at >= TIMEOUT - 1 && fired_at <= TIMEOUT + 1), 32'd1);
        chk("timeout other errs", 32'((n_csum - s_csum) + (n_len - s_len) + (n_ovr - s_ovr)), 32'd0);
        run_vec(0);

        // Hold a packet, provoke an overrun, then ack together with a new SYNC.
        run_vec(7);
        snap();
        send_byte(8'h55);
        tick();
        chk("ovr pulse", 32'(n_ovr - s_ovr), 32'd1);
        chk("ovr still valid", 32'(bus.PKT_VALID), 32'd1);
        chk("ovr addr", 32'(bus.PKT_ADDR), 32'h12);
        for (int i = 0; i < 3; i++) begin
            bus.RD_IDX = 4'(i);
            tick();
            chk($sformatf("ovr rd[%0d]", i), 32'(bus.RD_DATA), 32'(8'h0A + 8'(i)));
        end
        snap();
        bus.PKT_ACK = 1'b1;
        send_byte(8'h55);
        bus.PKT_ACK = 1'b0;
        chk("ack+sync valid", 32'(bus.PKT_VALID), 32'd0);
        send_byte(8'h01);
        send_byte(8'h01);
        send_byte(8'hAA);
        send_byte(8'hAC);
        chk("ack+sync new valid", 32'(bus.PKT_VALID), 32'd1);
        chk("ack+sync new addr", 32'(bus.PKT_ADDR), 32'h01);
        chk("ack+sync new len", 32'(bus.PKT_LEN), 32'h01);
        bus.RD_IDX = 4'd0;
        tick();
        chk("ack+sync rd[0]", 32'(bus.RD_DATA), 32'hAA);
        chk("ack+sync no ovr", 32'(n_ovr - s_ovr), 32'd0);
        bus.PKT_ACK = 1'b1;
        tick();
        bus.PKT_ACK = 1'b0;
        chk("ack+sync release", 32'(bus.PKT_VALID), 32'd0);

        // Ack while nothing is held must not disturb a following frame.
        bus.PKT_ACK = 1'b1;
        tick();
        bus.PKT_ACK = 1'b0;

        // Reset partway through a frame.
        snap();
        send_byte(8'h55);
        send_byte(8'h12);
        send_byte(8'h03);
        send_byte(8'h0A);
        rst = 1'b1;
        tick();
        chk("mid rst valid", 32'(bus.PKT_VALID), 32'd0);
        chk("mid rst addr", 32'(bus.PKT_ADDR), 32'd0);
        chk("mid rst len", 32'(bus.PKT_LEN), 32'd0);
        chk("mid rst rd_data", 32'(bus.RD_DATA), 32'd0);
        rst = 1'b0;
        tick();
        chk("mid rst no errs", 32'((n_csum - s_csum) + (n_len - s_len) + (n_to - s_to) + (n_ovr - s_ovr)), 32'd0);
        run_vec(0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
